// File: rtl/hline_pkg.sv
// Shared definitions for the hline setup stage: FSM encoding, raster defaults
// and the single-step restoring-division helper used by hline_div.
package hline_pkg;

  localparam int H_RES_DEFAULT   = 640;
  localparam int V_RES_DEFAULT   = 480;
  localparam int BYTES_PER_PIXEL = 4;
  localparam int DIV_CYCLES      = 32;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CAPTURE = 4'd1,
    S_ADDR    = 4'd2,
    S_DIV     = 4'd3,
    S_ISSUE   = 4'd4,
    S_WAIT_LO = 4'd5,
    S_WAIT_HI = 4'd6,
    S_FIN     = 4'd7,
    S_REJECT  = 4'd8
  } state_e;

  // Partial remainder plus the dividend bits still to be shifted in; the
  // quotient bits fill the low end of quo as the dividend drains out the top.
  typedef struct packed {
    logic [15:0] rem;
    logic [31:0] quo;
  } div_state_t;

  function automatic div_state_t div_step(input div_state_t s, input logic [15:0] divisor);
    div_state_t  n;
    logic [16:0] trial;
    logic [16:0] diff;
    trial = {s.rem, s.quo[31]};
    diff  = trial - {1'b0, divisor};
    if (trial >= {1'b0, divisor}) begin
      n.rem = diff[15:0];
      n.quo = {s.quo[30:0], 1'b1};
    end else begin
      n.rem = trial[15:0];
      n.quo = {s.quo[30:0], 1'b0};
    end
    return n;
  endfunction

endpackage

// File: rtl/hline_div.sv
// Unsigned 32/16 radix-2 restoring divider with a fixed 32-cycle latency:
// valid pulses exactly DIV_CYCLES cycles after the cycle in which load is high.
module hline_div
  import hline_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        valid,
  output logic [31:0] quotient,
  output logic [15:0] remainder
);

  div_state_t  st_q;
  logic [15:0] div_q;
  logic [5:0]  cnt_q;
  logic        busy_q;
  logic        valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (load) begin
        // The first iteration runs on the load edge so the result lands on time.
        st_q   <= div_step(div_state_t'({16'd0, dividend}), divisor);
        div_q  <= divisor;
        cnt_q  <= 6'd1;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        st_q  <= div_step(st_q, div_q);
        cnt_q <= cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_CYCLES - 1)) begin
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign quotient  = st_q.quo;
  assign remainder = st_q.rem;

endmodule

// File: rtl/hline_setup.sv
// Span setup for the hline z-buffer fill engine: orders endpoints, computes
// buffer addresses, pixel count and z slope, then runs the hl_start/hl_done handshake.
module hline_setup
  import hline_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] x1,
  input  logic [10:0] x2,
  input  logic [9:0]  y,
  input  logic [31:0] z1_in,
  input  logic [31:0] z2_in,
  input  logic [31:0] rgbx_in,
  input  logic [31:0] fb_base,
  input  logic [31:0] zb_base,
  output logic        busy,
  output logic        done,
  output logic        rejected,
  output logic        hl_start,
  input  logic        hl_done,
  output logic [31:0] fb_addr,
  output logic [31:0] zbuff_addr,
  output logic [31:0] dx,
  output logic [31:0] slope,
  output logic [31:0] rem,
  output logic [31:0] err,
  output logic [31:0] z1,
  output logic [31:0] rgbx
);

  state_e      state_q;
  logic [10:0] xl_q, xr_q;
  logic [9:0]  y_q;
  logic [31:0] zl_q, zr_q;
  logic [31:0] fb_base_q, zb_base_q;
  logic        dz_neg_q;
  logic        busy_q, done_q, rejected_q, hl_start_q;
  logic [31:0] fb_addr_q, zbuff_addr_q, dx_q, slope_q, rem_q, z1_q, rgbx_q;

  logic [10:0] xl_d, xr_d;
  logic [31:0] zl_d, zr_d;
  logic        reject_d;
  logic [32:0] dz_d;
  logic [31:0] dz_mag_d, dx_d, pix_idx_d, byte_off_d;

  logic        div_busy, div_valid;
  logic [31:0] div_quo;
  logic [15:0] div_rem;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    xl_d = x1;
    xr_d = x2;
    zl_d = z1_in;
    zr_d = z2_in;
    if (x2 < x1) begin
      xl_d = x2;
      xr_d = x1;
      zl_d = z2_in;
      zr_d = z1_in;
    end
  end

  assign reject_d   = (32'(xr_d) >= 32'(H_RES)) || (32'(y) >= 32'(V_RES));

  // dz needs 33 bits: the difference of two full-range signed depths.
  assign dz_d       = {zr_q[31], zr_q} - {zl_q[31], zl_q};
  assign dz_mag_d   = dz_d[32] ? (32'd0 - dz_d[31:0]) : dz_d[31:0];
  assign dx_d       = 32'(xr_q) - 32'(xl_q) + 32'd1;
  assign pix_idx_d  = 32'(y_q) * 32'(H_RES) + 32'(xl_q);
  assign byte_off_d = pix_idx_d * 32'(BYTES_PER_PIXEL);

  hline_div u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (state_q == S_ADDR),
    .dividend  (dz_mag_d),
    .divisor   (dx_d[15:0]),
    .busy      (div_busy),
    .valid     (div_valid),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      xl_q         <= '0;
      xr_q         <= '0;
      y_q          <= '0;
      zl_q         <= '0;
      zr_q         <= '0;
      fb_base_q    <= '0;
      zb_base_q    <= '0;
      dz_neg_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rejected_q   <= 1'b0;
      hl_start_q   <= 1'b0;
      fb_addr_q    <= '0;
      zbuff_addr_q <= '0;
      dx_q         <= '0;
      slope_q      <= '0;
      rem_q        <= '0;
      z1_q         <= '0;
      rgbx_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      hl_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          xl_q       <= xl_d;
          xr_q       <= xr_d;
          y_q        <= y;
          zl_q       <= zl_d;
          zr_q       <= zr_d;
          z1_q       <= zl_d;
          rgbx_q     <= rgbx_in;
          fb_base_q  <= fb_base;
          zb_base_q  <= zb_base;
          rejected_q <= 1'b0;
          if (reject_d) begin
            state_q    <= S_REJECT;
            rejected_q <= 1'b1;
            done_q     <= 1'b1;
          end else begin
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          fb_addr_q    <= fb_base_q + byte_off_d;
          zbuff_addr_q <= zb_base_q + byte_off_d;
          dx_q         <= dx_d;
          dz_neg_q     <= dz_d[32];
          state_q      <= S_DIV;
        end
        S_DIV: begin
          if (div_valid) begin
            slope_q    <= dz_neg_q ? (32'd0 - div_quo) : div_quo;
            rem_q      <= {16'd0, div_rem};
            hl_start_q <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_WAIT_LO;
        S_WAIT_LO: begin
          if (!hl_done) state_q <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (hl_done) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_FIN, S_REJECT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q | div_busy;
  assign done       = done_q;
  assign rejected   = rejected_q;
  assign hl_start   = hl_start_q;
  assign fb_addr    = fb_addr_q;
  assign zbuff_addr = zbuff_addr_q;
  assign dx         = dx_q;
  assign slope      = slope_q;
  assign rem        = rem_q;
  assign err        = 32'd0;
  assign z1         = z1_q;
  assign rgbx       = rgbx_q;

endmodule

// File: tb/tb_hline_setup.sv
// Self-checking bench for hline_setup: directed spans, randomized spans and
// rejects, reset mid-division, and a fill-engine model driving hl_done.
module tb_hline_setup;

  localparam int H = 640;
  localparam int V = 480;

  logic        clk = 1'b0;
  logic        reset, start, hl_done;
  logic [10:0] x1, x2;
  logic [9:0]  y;
  logic [31:0] z1_in, z2_in, rgbx_in, fb_base, zb_base;
  logic        busy, done, rejected, hl_start;
  logic [31:0] fb_addr, zbuff_addr, dx, slope, rem, err, z1, rgbx;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hline_setup #(.H_RES(H), .V_RES(V)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x1         (x1),
    .x2         (x2),
    .y          (y),
    .z1_in      (z1_in),
    .z2_in      (z2_in),
    .rgbx_in    (rgbx_in),
    .fb_base    (fb_base),
    .zb_base    (zb_base),
    .busy       (busy),
    .done       (done),
    .rejected   (rejected),
    .hl_start   (hl_start),
    .hl_done    (hl_done),
    .fb_addr    (fb_addr),
    .zbuff_addr (zbuff_addr),
    .dx         (dx),
    .slope      (slope),
    .rem        (rem),
    .err        (err),
    .z1         (z1),
    .rgbx       (rgbx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one span and plays the fill engine; lo = cycles hl_done is held low.
  task automatic run_span(input string name, input logic [10:0] a, input logic [10:0] b,
                          input logic [9:0] yy, input logic [31:0] za, input logic [31:0] zb,
                          input logic [31:0] col, input logic [31:0] fbb, input logic [31:0] zbb,
                          input int lo, input bit stray);
    logic [10:0] xl, xr;
    logic [31:0] zl, zr, e_slope, e_rem, e_fb, e_zb;
    longint      dz, mag;
    int          dxv, n, t_start, t_done, t_high, lo_left, starts;

    xl  = (a <= b) ? a : b;
    xr  = (a <= b) ? b : a;
    zl  = (a <= b) ? za : zb;
    zr  = (a <= b) ? zb : za;
    dz  = longint'($signed(zr)) - longint'($signed(zl));
    mag = ((dz < 0) ? -dz : dz) & 64'hFFFF_FFFF;
    dxv = int'(xr) - int'(xl) + 1;
    e_slope = (dz < 0) ? 32'(-(mag / dxv)) : 32'(mag / dxv);
    e_rem   = 32'(mag % dxv);
    e_fb    = fbb + 32'((int'(yy) * H + int'(xl)) * 4);
    e_zb    = zbb + 32'((int'(yy) * H + int'(xl)) * 4);

    x1 = a; x2 = b; y = yy; z1_in = za; z2_in = zb; rgbx_in = col;
    fb_base = fbb; zb_base = zbb;
    start = 1'b1;
    n = cyc;
    t_start = -1; t_done = -1; t_high = -1; lo_left = 0; starts = 0;
    for (int k = 0; k < 400 && t_done < 0; k++) begin
      @(negedge clk);
      if (cyc == n + 1) start = 1'b0;
      if (stray && cyc == n + 45) start = 1'b1;
      if (stray && cyc == n + 46) start = 1'b0;
      if (hl_start) begin
        starts++;
        if (t_start < 0) begin
          t_start = cyc;
          check({name, " fb_addr"}, fb_addr, e_fb);
          check({name, " zbuff_addr"}, zbuff_addr, e_zb);
          check({name, " dx"}, dx, 32'(dxv));
          check({name, " slope"}, slope, e_slope);
          check({name, " rem"}, rem, e_rem);
          check({name, " err"}, err, 32'd0);
          check({name, " z1"}, z1, zl);
          check({name, " rgbx"}, rgbx, col);
          check({name, " busy"}, 32'(busy), 32'd1);
          check({name, " rejected"}, 32'(rejected), 32'd0);
          hl_done = 1'b0;
          lo_left = lo;
        end
      end else if (t_start >= 0 && t_high < 0) begin
        lo_left--;
        if (lo_left == 0) begin
          hl_done = 1'b1;
          t_high = cyc;
        end
      end
      if (done) t_done = cyc;
    end
    hl_done = 1'b1;
    start = 1'b0;
    check({name, " hl_start_cycle"}, 32'(t_start - n), 32'd35);
    check({name, " hl_start_count"}, 32'(starts), 32'd1);
    check({name, " done_cycle"}, 32'(t_done - t_high), 32'd1);
    @(negedge clk);
    check({name, " done_width"}, 32'(done), 32'd0);
    check({name, " busy_after"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({name, " busy_idle"}, 32'(busy), 32'd0);
    check({name, " held_slope"}, slope, e_slope);
    check({name, " held_fb_addr"}, fb_addr, e_fb);
  endtask

  task automatic run_reject(input string name, input logic [10:0] a, input logic [10:0] b,
                            input logic [9:0] yy);
    int n, t_done, starts;
    x1 = a; x2 = b; y = yy; z1_in = $urandom; z2_in = $urandom;
    start = 1'b1;
    n = cyc;
    t_done = -1; starts = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cyc == n + 1) start = 1'b0;
      if (hl_start) starts++;
      if (done && t_done < 0) t_done = cyc;
    end
    check({name, " done_cycle"}, 32'(t_done - n), 32'd2);
    check({name, " no_hl_start"}, 32'(starts), 32'd0);
    check({name, " rejected"}, 32'(rejected), 32'd1);
    check({name, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [10:0] a, b;
    logic [9:0]  yy;
    int          n, starts;

    reset = 1'b1; start = 1'b0; hl_done = 1'b1;
    x1 = '0; x2 = '0; y = '0; z1_in = '0; z2_in = '0; rgbx_in = '0;
    fb_base = '0; zb_base = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hl_start", 32'(hl_start), 32'd0);
    check("reset rejected", 32'(rejected), 32'd0);
    check("reset dx", dx, 32'd0);
    check("reset fb_addr", fb_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_span("s1", 11'd10, 11'd19, 10'd0, 32'd100, 32'd130, 32'hA1B2C3D4, 32'd0, 32'd0, 5, 1'b0);
    run_span("s2", 11'd19, 11'd10, 10'd0, 32'd130, 32'd100, 32'hA1B2C3D4, 32'd0, 32'd0, 5, 1'b0);
    run_span("s3", 11'd0, 11'd2, 10'd0, 32'd10, 32'd0, 32'h0, 32'd0, 32'd0, 4, 1'b0);
    run_span("s4", 11'd5, 11'd5, 10'd2, 32'hFFFF_FF00, 32'd7, 32'h1, 32'h1000_0000, 32'h2000_0000, 3, 1'b0);
    run_span("edge", 11'd639, 11'd0, 10'd479, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5, 32'hFFFF_FFF0, 32'h0, 3, 1'b0);

    run_reject("s5", 11'd10, 11'd640, 10'd0);
    repeat (5) @(negedge clk);
    check("s5 rejected_sticky", 32'(rejected), 32'd1);
    run_reject("y_oob", 11'd1, 11'd2, 10'd480);
    run_span("after_rej", 11'd100, 11'd300, 10'd100, 32'd5000, 32'hFFFF_0000, 32'h77, 32'h400, 32'h800, 6, 1'b0);

    // Reset lands in DIV; the run must abort with no launch.
    x1 = 11'd10; x2 = 11'd19; y = '0; z1_in = 32'd100; z2_in = 32'd130;
    start = 1'b1;
    n = cyc;
    starts = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (cyc == n + 1) start = 1'b0;
      if (cyc == n + 19) check("s6 busy_in_div", 32'(busy), 32'd1);
      if (cyc == n + 20) reset = 1'b1;
      if (cyc == n + 21) begin
        reset = 1'b0;
        check("s6 reset_busy", 32'(busy), 32'd0);
        check("s6 reset_dx", dx, 32'd0);
        check("s6 reset_fb_addr", fb_addr, 32'd0);
        check("s6 reset_slope", slope, 32'd0);
      end
      if (hl_start) starts++;
    end
    check("s6 no_hl_start", 32'(starts), 32'd0);
    run_span("s6_long", 11'd3, 11'd40, 10'd7, 32'd1000, 32'd0, 32'hCAFE, 32'h100, 32'h200, 50, 1'b1);

    for (int i = 0; i < 16; i++) begin
      a  = 11'($urandom_range(0, H - 1));
      b  = (i % 5 == 0) ? a : 11'($urandom_range(0, H - 1));
      yy = 10'($urandom_range(0, V - 1));
      run_span($sformatf("rnd%0d", i), a, b, yy, $urandom, $urandom, $urandom,
               $urandom, $urandom, int'($urandom_range(3, 12)), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) run_reject($sformatf("rrej%0d", i), 11'($urandom_range(0, H - 1)),
                                 11'($urandom_range(H, 2047)), 10'($urandom_range(0, V - 1)));
      else            run_reject($sformatf("rrej%0d", i), 11'($urandom_range(0, H - 1)),
                                 11'($urandom_range(0, H - 1)), 10'($urandom_range(V, 1023)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
